// File: rtl/fetch_ctrl.sv
// fetch_ctrl
//
// Sequences the instruction-fetch unit against a variable-latency instruction
// memory. It issues one request per PC and hands the returned instruction to
// the D-stage register. It asserts pc_en only on the cycle D takes an
// instruction, so the IFU's npc is formed from the D-stage fields present on
// that same edge. If the hazard unit is stalling when the word arrives, the
// word is parked in a one-entry buffer until the stall clears.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   pc_in               current PC from the IFU
//   stall_in            data-hazard stall (does not include fetch busy)
//   pc_en               IFU enable, PC loads npc on this edge
//   imem_req/imem_addr  fetch request and address to instruction memory
//   imem_ack/imem_rdata one-cycle acknowledge with the fetched word
//   d_en/d_instr/d_pc   D-stage register write enable, instruction and PC
//   fetch_busy          no instruction deliverable this cycle
//   timeout             sticky watchdog flag
//   fetch_cnt           instructions delivered
//   wait_cnt            cycles spent with fetch_busy asserted
module fetch_ctrl #(
  parameter int WAIT_LIMIT = 16,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      pc_in,
  input  logic             stall_in,
  output logic             pc_en,
  output logic             imem_req,
  output logic [31:0]      imem_addr,
  input  logic             imem_ack,
  input  logic [31:0]      imem_rdata,
  output logic             d_en,
  output logic [31:0]      d_instr,
  output logic [31:0]      d_pc,
  output logic             fetch_busy,
  output logic             timeout,
  output logic [CNT_W-1:0] fetch_cnt,
  output logic [CNT_W-1:0] wait_cnt
);

  localparam int WC_W = $clog2(WAIT_LIMIT + 1);
  localparam logic [WC_W-1:0] LIMIT = WC_W'(WAIT_LIMIT);

  typedef enum logic {
    FETCH = 1'b0,
    HOLD  = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [31:0]       buf_instr_q, buf_instr_d;
  logic [31:0]       buf_pc_q, buf_pc_d;
  logic [WC_W-1:0]   wait_ctr_q, wait_ctr_d;
  logic              timeout_q, timeout_d;
  logic [CNT_W-1:0]  fetch_cnt_q, fetch_cnt_d;
  logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= FETCH;
      buf_instr_q <= '0;
      buf_pc_q    <= '0;
      wait_ctr_q  <= '0;
      timeout_q   <= 1'b0;
      fetch_cnt_q <= '0;
      wait_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      buf_instr_q <= buf_instr_d;
      buf_pc_q    <= buf_pc_d;
      wait_ctr_q  <= wait_ctr_d;
      timeout_q   <= timeout_d;
      fetch_cnt_q <= fetch_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
    end
  end

  // Outputs are held quiet during reset so no request or delivery leaks out
  // while memory is also being reset.
  always_comb begin
    state_d     = state_q;
    buf_instr_d = buf_instr_q;
    buf_pc_d    = buf_pc_q;
    wait_ctr_d  = wait_ctr_q;
    timeout_d   = timeout_q;
    fetch_cnt_d = fetch_cnt_q;
    wait_cnt_d  = wait_cnt_q;
    imem_req    = 1'b0;
    pc_en       = 1'b0;
    d_en        = 1'b0;
    d_instr     = '0;
    d_pc        = pc_in;
    fetch_busy  = 1'b0;

    if (!reset) begin
      unique case (state_q)
        FETCH: begin
          imem_req = 1'b1;
          if (imem_ack) begin
            wait_ctr_d = '0;
            if (!stall_in) begin
              d_en        = 1'b1;
              pc_en       = 1'b1;
              d_instr     = imem_rdata;
              fetch_cnt_d = fetch_cnt_q + CNT_W'(1);
            end else begin
              buf_instr_d = imem_rdata;
              buf_pc_d    = pc_in;
              state_d     = HOLD;
            end
          end else begin
            fetch_busy = 1'b1;
            wait_cnt_d = wait_cnt_q + CNT_W'(1);
            // Saturate so a long-dead memory cannot wrap the watchdog back
            // below the limit.
            if (wait_ctr_q != LIMIT) begin
              wait_ctr_d = wait_ctr_q + WC_W'(1);
            end
            if (wait_ctr_d == LIMIT) begin
              timeout_d = 1'b1;
            end
          end
        end
        HOLD: begin
          // Any ack seen here has no request behind it and is ignored.
          if (!stall_in) begin
            d_en        = 1'b1;
            pc_en       = 1'b1;
            d_instr     = buf_instr_q;
            d_pc        = buf_pc_q;
            fetch_cnt_d = fetch_cnt_q + CNT_W'(1);
            wait_ctr_d  = '0;
            state_d     = FETCH;
          end
        end
        default: state_d = FETCH;
      endcase
    end
  end

  assign imem_addr = pc_in;
  assign timeout   = timeout_q;
  assign fetch_cnt = fetch_cnt_q;
  assign wait_cnt  = wait_cnt_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed testbench for fetch_ctrl. A small IFU model holds the PC and
// loads npc on pc_en. npc is the branch target when the instruction sitting
// in D is the test branch, otherwise PC+4.
module tb_fetch_ctrl;

  localparam logic [31:0] RESET_PC   = 32'h0000_3000;
  localparam logic [31:0] BR_WORD    = 32'h1000_0003;
  localparam logic [31:0] BR_TARGET  = 32'h0000_4000;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc;
  logic        stall_in;
  logic        pc_en;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        d_en;
  logic [31:0] d_instr;
  logic [31:0] d_pc;
  logic        fetch_busy;
  logic        timeout;
  logic [31:0] fetch_cnt;
  logic [31:0] wait_cnt;

  int vectors = 0;
  int miscompares = 0;

  logic d_is_branch;

  fetch_ctrl #(.WAIT_LIMIT(16), .CNT_W(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .pc_in      (pc),
    .stall_in   (stall_in),
    .pc_en      (pc_en),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .d_en       (d_en),
    .d_instr    (d_instr),
    .d_pc       (d_pc),
    .fetch_busy (fetch_busy),
    .timeout    (timeout),
    .fetch_cnt  (fetch_cnt),
    .wait_cnt   (wait_cnt)
  );

  always #5 clk = ~clk;

  // IFU and D-stage model: PC advances only on pc_en, using the branch that
  // is in D on that same edge.
  always @(posedge clk) begin
    if (reset) begin
      pc          <= RESET_PC;
      d_is_branch <= 1'b0;
    end else begin
      if (pc_en) pc <= d_is_branch ? BR_TARGET : pc + 32'd4;
      if (d_en) d_is_branch <= (d_instr == BR_WORD);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    imem_ack = 1'b0;
    stall_in = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    imem_ack = 1'b1;
    imem_rdata = 32'hdead_beef;
    stall_in = 1'b0;
    #1;
    vectors++;
    if (pc_en !== 1'b0 || d_en !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_en: pc_en=%b d_en=%b expected 0/0", pc_en, d_en);
    end
    tick();
    reset = 1'b0;
    imem_ack = 1'b0;
    #1;
    vectors++;
    if (fetch_cnt !== 32'd0 || wait_cnt !== 32'd0 || timeout !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_state: fetch_cnt=%0d wait_cnt=%0d timeout=%b expected 0/0/0",
               fetch_cnt, wait_cnt, timeout);
    end
  endtask

  task automatic test_first_fetch();
    imem_ack = 1'b1;
    imem_rdata = 32'h3c01_0001;
    stall_in = 1'b0;
    #1;
    vectors++;
    if (d_en !== 1'b1 || pc_en !== 1'b1 || d_instr !== 32'h3c01_0001 || d_pc !== 32'h3000
        || imem_req !== 1'b1 || imem_addr !== 32'h3000) begin
      miscompares++;
      $display("[TB] FAIL first_fetch: d_en=%b pc_en=%b d_instr=%h d_pc=%h req=%b addr=%h expected 1/1/3c010001/3000/1/3000",
               d_en, pc_en, d_instr, d_pc, imem_req, imem_addr);
    end
    tick();
    imem_ack = 1'b0;
    #1;
    vectors++;
    if (fetch_cnt !== 32'd1 || imem_addr !== 32'h3004 || imem_req !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL first_fetch_next: fetch_cnt=%0d addr=%h req=%b expected 1/3004/1",
               fetch_cnt, imem_addr, imem_req);
    end
  endtask

  task automatic test_latency();
    imem_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      vectors++;
      if (fetch_busy !== 1'b1 || d_en !== 1'b0 || pc_en !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL latency_busy[%0d]: busy=%b d_en=%b pc_en=%b expected 1/0/0",
                 i, fetch_busy, d_en, pc_en);
      end
      tick();
    end
    imem_ack = 1'b1;
    imem_rdata = 32'h2402_0005;
    #1;
    vectors++;
    if (fetch_busy !== 1'b0 || d_en !== 1'b1 || d_pc !== 32'h3004 || d_instr !== 32'h2402_0005
        || wait_cnt !== 32'd3) begin
      miscompares++;
      $display("[TB] FAIL latency_deliver: busy=%b d_en=%b d_pc=%h d_instr=%h wait_cnt=%0d expected 0/1/3004/24020005/3",
               fetch_busy, d_en, d_pc, d_instr, wait_cnt);
    end
    tick();
    imem_ack = 1'b0;
    #1;
    vectors++;
    if (fetch_cnt !== 32'd2 || wait_cnt !== 32'd3 || imem_addr !== 32'h3008) begin
      miscompares++;
      $display("[TB] FAIL latency_after: fetch_cnt=%0d wait_cnt=%0d addr=%h expected 2/3/3008",
               fetch_cnt, wait_cnt, imem_addr);
    end
  endtask

  task automatic test_stall_hold();
    imem_ack = 1'b1;
    imem_rdata = 32'h8c43_0010;
    stall_in = 1'b1;
    #1;
    vectors++;
    if (d_en !== 1'b0 || pc_en !== 1'b0 || d_instr !== 32'h0) begin
      miscompares++;
      $display("[TB] FAIL stall_capture: d_en=%b pc_en=%b d_instr=%h expected 0/0/0",
               d_en, pc_en, d_instr);
    end
    tick();
    // Spurious acks with a different word while holding must not be taken.
    imem_rdata = 32'hbad0_bad0;
    for (int i = 0; i < 2; i++) begin
      #1;
      vectors++;
      if (imem_req !== 1'b0 || pc_en !== 1'b0 || d_en !== 1'b0 || fetch_busy !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL hold[%0d]: req=%b pc_en=%b d_en=%b busy=%b expected 0/0/0/0",
                 i, imem_req, pc_en, d_en, fetch_busy);
      end
      tick();
    end
    stall_in = 1'b0;
    imem_ack = 1'b0;
    #1;
    vectors++;
    if (d_en !== 1'b1 || pc_en !== 1'b1 || d_instr !== 32'h8c43_0010 || d_pc !== 32'h3008) begin
      miscompares++;
      $display("[TB] FAIL hold_release: d_en=%b pc_en=%b d_instr=%h d_pc=%h expected 1/1/8c430010/3008",
               d_en, pc_en, d_instr, d_pc);
    end
    tick();
    #1;
    vectors++;
    if (fetch_cnt !== 32'd3 || d_en !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h300c) begin
      miscompares++;
      $display("[TB] FAIL hold_single: fetch_cnt=%0d d_en=%b req=%b addr=%h expected 3/0/1/300c",
               fetch_cnt, d_en, imem_req, imem_addr);
    end
  endtask

  task automatic test_watchdog();
    do_reset();
    imem_ack = 1'b0;
    for (int i = 0; i < 15; i++) tick();
    vectors++;
    if (timeout !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL wdog_early: timeout=%b expected 0 after 15 cycles", timeout);
    end
    tick();
    vectors++;
    if (timeout !== 1'b1 || wait_cnt !== 32'd16) begin
      miscompares++;
      $display("[TB] FAIL wdog_fire: timeout=%b wait_cnt=%0d expected 1/16", timeout, wait_cnt);
    end
    imem_ack = 1'b1;
    imem_rdata = 32'h0000_0020;
    #1;
    vectors++;
    if (d_en !== 1'b1 || d_pc !== 32'h3000) begin
      miscompares++;
      $display("[TB] FAIL wdog_continue: d_en=%b d_pc=%h expected 1/3000", d_en, d_pc);
    end
    tick();
    imem_ack = 1'b0;
    vectors++;
    if (timeout !== 1'b1 || fetch_cnt !== 32'd1) begin
      miscompares++;
      $display("[TB] FAIL wdog_sticky: timeout=%b fetch_cnt=%0d expected 1/1", timeout, fetch_cnt);
    end
    do_reset();
    vectors++;
    if (timeout !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL wdog_clear: timeout=%b expected 0", timeout);
    end
  endtask

  task automatic test_reset_mid();
    // Deliver one word so the PC moves off the reset value, then wait.
    imem_ack = 1'b1;
    imem_rdata = 32'h0000_0021;
    tick();
    imem_ack = 1'b0;
    tick();
    tick();
    do_reset();
    #1;
    vectors++;
    if (fetch_cnt !== 32'd0 || wait_cnt !== 32'd0 || imem_req !== 1'b1 || imem_addr !== 32'h3000) begin
      miscompares++;
      $display("[TB] FAIL reset_fetch: fetch_cnt=%0d wait_cnt=%0d req=%b addr=%h expected 0/0/1/3000",
               fetch_cnt, wait_cnt, imem_req, imem_addr);
    end
    imem_ack = 1'b1;
    imem_rdata = 32'h1234_5678;
    stall_in = 1'b1;
    tick();
    do_reset();
    imem_ack = 1'b0;
    stall_in = 1'b0;
    #1;
    vectors++;
    if (imem_req !== 1'b1 || d_en !== 1'b0 || d_instr !== 32'h0 || fetch_cnt !== 32'd0
        || imem_addr !== 32'h3000) begin
      miscompares++;
      $display("[TB] FAIL reset_hold: req=%b d_en=%b d_instr=%h fetch_cnt=%0d addr=%h expected 1/0/0/0/3000",
               imem_req, d_en, d_instr, fetch_cnt, imem_addr);
    end
  endtask

  task automatic test_branch_delay_slot();
    do_reset();
    imem_ack = 1'b1;
    imem_rdata = BR_WORD;
    stall_in = 1'b0;
    tick();
    imem_ack = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      vectors++;
      if (pc_en !== 1'b0 || imem_addr !== 32'h3004) begin
        miscompares++;
        $display("[TB] FAIL branch_wait[%0d]: pc_en=%b addr=%h expected 0/3004", i, pc_en, imem_addr);
      end
      tick();
    end
    imem_ack = 1'b1;
    imem_rdata = 32'h0000_0000;
    #1;
    vectors++;
    if (d_en !== 1'b1 || pc_en !== 1'b1 || d_pc !== 32'h3004) begin
      miscompares++;
      $display("[TB] FAIL branch_slot: d_en=%b pc_en=%b d_pc=%h expected 1/1/3004", d_en, pc_en, d_pc);
    end
    tick();
    imem_ack = 1'b0;
    #1;
    vectors++;
    if (imem_addr !== BR_TARGET || fetch_cnt !== 32'd2 || d_en !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL branch_target: addr=%h fetch_cnt=%0d d_en=%b expected 4000/2/0",
               imem_addr, fetch_cnt, d_en);
    end
  endtask

  initial begin
    reset = 1'b1;
    stall_in = 1'b0;
    imem_ack = 1'b0;
    imem_rdata = '0;
    test_reset();
    test_first_fetch();
    test_latency();
    test_stall_hold();
    test_watchdog();
    test_reset_mid();
    test_branch_delay_slot();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Sequences the IFU against a variable-latency instruction memory.
- Issues the fetch request for the current PC and delivers the instruction to the D-stage register.
- Generates the IFU `enable` (pc_en) so the PC advances only when D actually accepts an instruction. The IFU's npc is then always computed from the D-stage branch/jump fields present on that same edge.
- Buffers one instruction across data-hazard stalls, reports fetch-busy to the hazard unit, and keeps fetch statistics plus a watchdog.

Parameters:
- WAIT_LIMIT, 16, max consecutive cycles a request may stay unacknowledged before `timeout` is raised.
- CNT_W, 32, width of the performance counters.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- pc_in  input  32  current PC from IFU
- stall_in  input  1  data-hazard stall from the hazard unit (excludes fetch busy)
- pc_en  output  1  IFU enable; PC loads npc on this edge
- imem_req  output  1  fetch request to instruction memory
- imem_addr  output  32  fetch address (= pc_in)
- imem_ack  input  1  one-cycle pulse; imem_rdata valid in that cycle
- imem_rdata  input  32  fetched instruction
- d_en  output  1  D-stage register write enable
- d_instr  output  32  instruction to D register
- d_pc  output  32  PC of d_instr
- fetch_busy  output  1  no instruction deliverable this cycle; hazard unit freezes D and bubbles E
- timeout  output  1  sticky watchdog flag
- fetch_cnt  output  CNT_W  instructions delivered
- wait_cnt  output  CNT_W  cycles with fetch_busy=1

Behaviour:
- States: FETCH (request outstanding), HOLD (instruction buffered, waiting on stall_in).
- Reset: state=FETCH; buf, buf_pc, wait_ctr, fetch_cnt, wait_cnt cleared; timeout=0.
  - All outputs are combinational from state/inputs. In the reset cycle pc_en=0 and d_en=0.
  - Any outstanding request is abandoned; instruction memory shares the reset and drops it.
- FETCH:
  - imem_req=1, imem_addr=pc_in. pc_in is stable because pc_en=0 until delivery.
  - imem_ack=1 and stall_in=0: deliver. d_en=1, pc_en=1, d_instr=imem_rdata, d_pc=pc_in. Stay in FETCH; the next request uses the new PC the following cycle, so there is no back-to-back pipelining. fetch_cnt+1.
  - imem_ack=1 and stall_in=1: buf<=imem_rdata, buf_pc<=pc_in; go to HOLD. pc_en=0, d_en=0.
  - imem_ack=0: fetch_busy=1, pc_en=0, d_en=0, wait_cnt+1, wait_ctr+1.
- HOLD:
  - imem_req=0.
  - stall_in=0: d_en=1, pc_en=1, d_instr=buf, d_pc=buf_pc, fetch_cnt+1, go to FETCH.
  - stall_in=1: remain in HOLD.
  - fetch_busy=0 in HOLD; the stall is owned by the hazard unit.
- Outside delivery cycles: d_instr=0 (nop), d_pc=pc_in.
- Invariants:
  - pc_en == d_en in every cycle.
  - Never two deliveries per request.
  - imem_ack while imem_req=0 is ignored.
- Watchdog:
  - wait_ctr clears on every ack and on entering FETCH.
  - When wait_ctr reaches WAIT_LIMIT, timeout<=1; it is sticky until reset.
  - Fetching continues normally after timeout.
- Counters wrap modulo 2^CNT_W.
- Delay slot: the branch in D and its delay-slot fetch are handled purely by pc_en timing. No flush is performed.

Test Plan:
- Reset, then ack on 1st cycle with rdata=0x3c010001, stall_in=0 -> d_en=pc_en=1 that cycle, d_pc=0x3000, fetch_cnt=1; next request addr=0x3004.
- Ack latency 3 cycles -> fetch_busy=1 for 3 cycles, d_en=0 throughout, wait_cnt=3, deliver on 4th cycle.
- Ack with stall_in=1 held 2 more cycles -> HOLD, imem_req=0, no pc_en; on release d_instr=buffered word, d_pc unchanged, single delivery.
- No ack for WAIT_LIMIT=16 cycles -> timeout=1 on cycle 16 and stays 1 after a later ack; reset clears it.
- Reset asserted while in FETCH waiting and again while in HOLD -> state=FETCH, buffer discarded, counters 0, first request addr=pc_in (0x3000).
- Branch in D (IFU jumpOp=1, taken) with 2-cycle fetch latency -> PC loads target only on the delivery edge; delay-slot instruction delivered exactly once.
